aes_result_spi_tx: RTL and testbench
====================================

// Module: aes_result_spi_tx
// PURPOSE
//   SPI-style serial output stage downstream of the AES core. Captures each 128-bit
//   result block (ciphertext on doneenc, or plaintext on donedec) into a 2-entry buffer.
//   Shifts the buffered block out MSB-first on miso, one bit per clk, while the host
//   holds cs low. Decouples cipher completion from host read timing. Reports overflow
//   and transfer completion.
// PARAMETERS
//   DATASIZE  128  block width in bits; must be a power of two >= 8
//   DEPTH     2    buffer entries; fixed at 2 in this block
// PORTS
//   clk       in   1         single system clock; all logic rising-edge
//   rst       in   1         asynchronous, active-low reset
//   load      in   1         one-cycle pulse: capture data_in (wire to doneenc/donedec)
//   data_in   in   DATASIZE  result block from cipher/inv-cipher
//   cs        in   1         host chip select, active-low
//   miso      out  1         serial data out, MSB first
//   avail     out  1         buffer holds >= 1 unsent block
//   full      out  1         buffer holds DEPTH blocks
//   done      out  1         one-cycle pulse: a full block was shifted out
//   overflow  out  1         sticky: a load was dropped because the buffer was full
// BEHAVIOUR
//   Reset (rst=0, async): buffer empty, count=0, FSM=IDLE; miso, avail, full, done, overflow = 0.
//   Buffer: 2-entry FIFO, head = oldest block.
//     load while not full -> push data_in at that edge; avail rises the next cycle.
//     load while full -> data dropped, overflow set the next cycle. It stays set until reset.
//     load and pop on the same edge while full -> accepted: pop head, push new; no overflow.
//   FSM states: IDLE, SHIFT, WAIT_CSH.
//     IDLE: if cs=0 and avail=1 -> SHIFT; copy head into shreg; count=0.
//           if cs=0 and avail=0 -> WAIT_CSH; miso stays 0. An empty read is never shifted.
//     SHIFT: miso = shreg[DATASIZE-1] (registered, no comb path from cs).
//            Each clk with cs=0: shreg <<= 1, count++.
//            Bit k (k=0..DATASIZE-1) appears on miso during the k-th cycle after entry to SHIFT.
//            When count = DATASIZE-1 and cs=0: pulse done, pop head, -> WAIT_CSH.
//            cs=1 mid-block: abort; no pop, no done -> IDLE.
//              The same block is resent from its MSB on the next cs-low.
//     WAIT_CSH: miso=0; -> IDLE when cs=1. One block per cs-low window.
//   Latency: first bit on miso 1 clk after the first cs-low edge sampled in IDLE.
//     Whole block = DATASIZE cycles + 1.
//   count width = $clog2(DATASIZE); no wrap beyond DATASIZE-1.
//   load during SHIFT: legal; the shifting block is held in shreg and is unaffected.
//   Reset mid-transfer: everything cleared; buffered blocks are lost; overflow cleared.
//   miso is 0 in every state except SHIFT.
// STRUCTURE
//   Shared package aes_pkg: localparam AES_BLOCK_BITS=128; typedef enum for FSM
//     {IDLE, SHIFT, WAIT_CSH}; typedef logic [AES_BLOCK_BITS-1:0] aes_block_t.
//   Sub-module result_fifo2: 2-entry register FIFO.
//     Ports: push, pop, din, dout, empty, full, drop.
//     Same clk/rst convention; simultaneous push+pop when full is allowed.
//   Top: FSM, shift register, counter, overflow flag.
//     Top-level instantiation next to the existing data/key SPI receivers.
// TESTING
//   1. Reset, load 0x00112233_44556677_8899AABB_CCDDEEFF, hold cs=0 129 cycles.
//      -> miso reproduces the block MSB-first; done pulses once; avail=0.
//   2. Empty read: cs=0 with buffer empty for 20 cycles.
//      -> miso=0, no done; then cs=1 and a load -> next cs-low shifts the block.
//   3. Load A, B, then C while full.
//      -> full=1, overflow=1, C dropped.
//      -> Two reads return A then B; a third read gets miso=0.
//   4. Load A, start read, raise cs after 40 bits.
//      -> no done, avail stays 1; next read returns all of A from bit 127.
//   5. Load A and B; read A; on A's final cycle pulse load C.
//      -> pop and push on the same edge; no overflow; later reads give B then C.
//   6. Drop rst low during bit 60 of a read.
//      -> miso, avail, full, overflow = 0 immediately; FSM in IDLE after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, block type and the result SPI transmitter states.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS = 128;

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_CSH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry register FIFO for result blocks; head is always entry 0.
module result_fifo2
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = AES_BLOCK_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             v0;
  logic             v1;
  logic             pop_ok;

  assign pop_ok = pop & v0;
  // A push into a full FIFO is only lost when no pop frees a slot on the same edge.
  assign drop   = push & v1 & ~pop_ok;
  assign dout   = mem0;
  assign empty  = ~v0;
  assign full   = v1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0 <= '0;
      mem1 <= '0;
      v0   <= 1'b0;
      v1   <= 1'b0;
    end else if (pop_ok) begin
      if (push && v1) begin
        mem0 <= mem1;
        mem1 <= din;
      end else if (push) begin
        mem0 <= din;
      end else begin
        mem0 <= mem1;
        v0   <= v1;
        v1   <= 1'b0;
      end
    end else if (push) begin
      if (!v0) begin
        mem0 <= din;
        v0   <= 1'b1;
      end else if (!v1) begin
        mem1 <= din;
        v1   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_result_spi_tx.sv
// Buffers AES result blocks and shifts them out MSB-first on miso while the host holds cs low.
module aes_result_spi_tx
  import aes_pkg::*;
#(
  parameter int unsigned DATASIZE = AES_BLOCK_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                cs,
  output logic                miso,
  output logic                avail,
  output logic                full,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(DATASIZE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATASIZE - 1);

  tx_state_e           state;
  logic [DATASIZE-1:0] shreg;
  logic [CNT_W-1:0]    count;
  logic [DATASIZE-1:0] head;
  logic                fifo_empty;
  logic                fifo_full;
  logic                drop;
  logic                pop_c;

  // Pop coincides with the edge that completes the block (and raises done).
  assign pop_c = (state == SHIFT) & ~cs & (count == LAST_BIT);
  assign avail = ~fifo_empty;
  assign full  = fifo_full;

  result_fifo2 #(.WIDTH(DATASIZE)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load),
    .pop   (pop_c),
    .din   (data_in),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      miso     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (!cs) begin
            if (!fifo_empty) begin
              state <= SHIFT;
              shreg <= head;
              count <= '0;
              miso  <= head[DATASIZE-1];
            end else begin
              state <= WAIT_CSH;
            end
          end
        end
        SHIFT: begin
          if (cs) begin
            // Abort: the head stays buffered and is resent from its MSB.
            state <= IDLE;
            miso  <= 1'b0;
          end else if (count == LAST_BIT) begin
            state <= WAIT_CSH;
            done  <= 1'b1;
            miso  <= 1'b0;
          end else begin
            shreg <= {shreg[DATASIZE-2:0], 1'b0};
            count <= count + CNT_W'(1);
            miso  <= shreg[DATASIZE-2];
          end
        end
        WAIT_CSH: begin
          miso <= 1'b0;
          if (cs) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_result_spi_tx.sv
// Randomized self-checking bench for aes_result_spi_tx against a queue-based host-view model.
module tb_aes_result_spi_tx;

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] data_in;
  logic         cs;
  logic         miso;
  logic         avail;
  logic         full;
  logic         done;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  logic [127:0] mq[$];
  bit           ovf;

  aes_result_spi_tx dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .cs       (cs),
    .miso     (miso),
    .avail    (avail),
    .full     (full),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_load(input logic [127:0] d);
    if (mq.size() < 2) mq.push_back(d);
    else ovf = 1'b1;
  endfunction

  // Pulse load for one cycle and check the buffer flags against the model.
  task automatic load_blk(input logic [127:0] d);
    load = 1'b1;
    data_in = d;
    tick();
    load = 1'b0;
    model_load(d);
    checks++;
    if (avail !== (mq.size() > 0)) begin
      errors++; $display("FAIL load_avail: got %0b expected %0b", avail, mq.size() > 0);
    end
    checks++;
    if (full !== (mq.size() == 2)) begin
      errors++; $display("FAIL load_full: got %0b expected %0b", full, mq.size() == 2);
    end
    checks++;
    if (overflow !== ovf) begin
      errors++; $display("FAIL load_overflow: got %0b expected %0b", overflow, ovf);
    end
  endtask

  // Hold cs low for 'cycles' clocks, optionally pulsing load on the 129th; then raise cs.
  task automatic host_read(input int cycles, input bit load_at_last, input logic [127:0] ld);
    logic [127:0] blk;
    bit has;
    logic exp_miso;
    logic exp_done;
    has = (mq.size() > 0);
    blk = has ? mq[0] : '0;
    cs = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      if (load_at_last && k == 129) begin
        load = 1'b1;
        data_in = ld;
      end
      tick();
      load = 1'b0;
      if (k == 129) begin
        if (has) void'(mq.pop_front());
        if (load_at_last) model_load(ld);
      end
      exp_miso = (has && k <= 128) ? blk[128-k] : 1'b0;
      exp_done = has && (k == 129);
      checks++;
      if (miso !== exp_miso) begin
        errors++; $display("FAIL read_miso cycle %0d: got %0b expected %0b", k, miso, exp_miso);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL read_done cycle %0d: got %0b expected %0b", k, done, exp_done);
      end
    end
    cs = 1'b1;
    tick();
    checks++;
    if (miso !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL read_end: got miso=%0b done=%0b expected 0 0", miso, done);
    end
    checks++;
    if (avail !== (mq.size() > 0)) begin
      errors++; $display("FAIL read_avail: got %0b expected %0b", avail, mq.size() > 0);
    end
    checks++;
    if (full !== (mq.size() == 2) || overflow !== ovf) begin
      errors++;
      $display("FAIL read_flags: got full=%0b ovf=%0b expected %0b %0b",
               full, overflow, mq.size() == 2, ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cs = 1'b1; load = 1'b0; data_in = '0;
    mq.delete(); ovf = 1'b0;
    tick(); tick();
    checks++;
    if ({miso, avail, full, done, overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %05b expected 00000", {miso, avail, full, done, overflow});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_blk(128'h00112233_44556677_8899AABB_CCDDEEFF);
    host_read(129, 1'b0, '0);
  endtask

  task automatic test_empty_read();
    host_read(20, 1'b0, '0);
    load_blk(rand_blk());
    host_read(129, 1'b0, '0);
  endtask

  task automatic test_overflow();
    load_blk(rand_blk());
    load_blk(rand_blk());
    load_blk(rand_blk());
    host_read(129, 1'b0, '0);
    host_read(129, 1'b0, '0);
    host_read(20, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    load_blk(rand_blk());
    load_blk(rand_blk());
    load_blk(rand_blk());
    cs = 1'b0;
    for (int k = 0; k < 61; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    mq.delete(); ovf = 1'b0;
    checks++;
    if ({miso, avail, full, overflow, done} !== 5'b0) begin
      errors++; $display("FAIL reset_mid: got %05b expected 00000", {miso, avail, full, overflow, done});
    end
    cs = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    host_read(20, 1'b0, '0);
    load_blk(rand_blk());
    host_read(129, 1'b0, '0);
  endtask

  task automatic test_abort();
    load_blk(rand_blk());
    host_read(40, 1'b0, '0);
    host_read(129, 1'b0, '0);
  endtask

  task automatic test_pop_push();
    load_blk(rand_blk());
    load_blk(rand_blk());
    host_read(129, 1'b1, rand_blk());
    host_read(129, 1'b0, '0);
    host_read(129, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int n;
      int sel;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) load_blk(rand_blk());
      sel = $urandom_range(0, 3);
      case (sel)
        0: host_read($urandom_range(1, 128), 1'b0, '0);
        1: host_read(129, 1'b1, rand_blk());
        default: host_read($urandom_range(129, 134), 1'b0, '0);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_overflow();
    test_reset_mid();
    test_abort();
    test_pop_push();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
